// File: rtl/ahb_pkg.sv
// ahb_pkg: shared constants and FSM encoding for the AHB command issuer.
package ahb_pkg;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b100;
  localparam logic [SEL_W-1:0] SEL_MAX  = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } state_t;
endpackage

// File: rtl/ahb_cmd_issuer_if.sv
// ahb_cmd_issuer_if: command channel, ahb_top user-side pins and read
// response channel of the issuer. master = controller/bus-model side,
// slave = the issuer itself.
interface ahb_cmd_issuer_if import ahb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_wr;
  logic [SEL_W-1:0]         cmd_sel;
  logic [AW-1:0]            cmd_addr;
  logic [DW-1:0]            cmd_wdata;
  logic                     enable;
  logic [AW-1:0]            addr;
  logic                     wr;
  logic [SEL_W-1:0]         sel;
  logic [DW-1:0]            dina;
  logic [DW-1:0]            dout;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DW-1:0]            rsp_rdata;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_wdata, dout, rsp_ready,
    input  cmd_ready, enable, addr, wr, sel, dina, rsp_valid, rsp_rdata, busy, count
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_wdata, dout, rsp_ready,
    output cmd_ready, enable, addr, wr, sel, dina, rsp_valid, rsp_rdata, busy, count
  );
endinterface

// File: rtl/ahb_sync_fifo.sv
// ahb_sync_fifo: single-clock FIFO, DEPTH a power of two, synchronous
// active-high reset flushes pointers and occupancy.
module ahb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // Full blocks pushes even when a pop lands on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage; contents need no reset since the pointers define validity.
  always_ff @(posedge hclk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ahb_cmd_issuer.sv
// ahb_cmd_issuer: buffers bus commands and replays them onto ahb_top's
// user pins as ADDR -> DATA (-> WAIT for reads) -> GAP, returning read
// data on a valid/ready response channel.
// Optional macro ISSUER_SELCHK_EN: drop commands with sel > SEL_MAX and
// flag them on the sticky err_drop output.
module ahb_cmd_issuer import ahb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic hclk,
  input  logic hresetn,
`ifdef ISSUER_SELCHK_EN
  output logic err_drop,
`endif
  ahb_cmd_issuer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef struct packed {
    logic             wr;
    logic [SEL_W-1:0] sel;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
  } cmd_t;

  cmd_t             push_cmd, head;
  logic             push, pop, full, empty, capture;
  logic [CNT_W-1:0] fifo_cnt;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] wcnt, wcnt_n;
  logic             en_q, en_n, wr_q, wr_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [DW-1:0]    dina_q, dina_n;
  logic             cq_wr, cq_wr_n;
  logic [DW-1:0]    cq_wdata, cq_wdata_n;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_rdata_q;

  assign push_cmd      = '{wr: bus.cmd_wr, sel: bus.cmd_sel, addr: bus.cmd_addr,
                           wdata: bus.cmd_wdata};
  assign bus.cmd_ready = !full;

`ifdef ISSUER_SELCHK_EN
  logic accept, bad_sel;
  assign accept  = bus.cmd_valid && !full;
  assign bad_sel = (bus.cmd_sel > SEL_MAX);
  assign push    = accept && !bad_sel;

  // Sticky record of any accepted-but-dropped command.
  always_ff @(posedge hclk) begin
    if (hresetn)               err_drop <= 1'b0;
    else if (accept && bad_sel) err_drop <= 1'b1;
  end
`else
  assign push = bus.cmd_valid && !full;
`endif

  ahb_sync_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .hclk    (hclk),
    .hresetn (hresetn),
    .push    (push),
    .pop     (pop),
    .wdata   (push_cmd),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_cnt)
  );

  // Next state and next bus values; the bus registers load together with
  // the state so each state's pins are visible while the FSM sits in it.
  always_comb begin
    state_nxt  = state;
    wcnt_n     = wcnt;
    en_n       = en_q;
    wr_n       = wr_q;
    addr_n     = addr_q;
    sel_n      = sel_q;
    dina_n     = dina_q;
    cq_wr_n    = cq_wr;
    cq_wdata_n = cq_wdata;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        cq_wr_n    = head.wr;
        cq_wdata_n = head.wdata;
        en_n       = 1'b1;
        addr_n     = head.addr;
        sel_n      = head.sel;
        wr_n       = head.wr;
        state_nxt  = ADDR;
      end
      ADDR: begin
        if (cq_wr) dina_n = cq_wdata;
        wr_n      = cq_wr;
        state_nxt = DATA;
      end
      DATA: if (cq_wr) begin
        en_n      = 1'b0;
        wr_n      = 1'b0;
        sel_n     = SEL_NONE;
        state_nxt = GAP;
      end else begin
        wcnt_n    = '0;
        state_nxt = WAIT;
      end
      WAIT: if (wcnt == LAT_LAST) begin
        // Hold the bus until the response slot is free (or freeing now).
        if (!rsp_valid_q || bus.rsp_ready) begin
          capture   = 1'b1;
          en_n      = 1'b0;
          wr_n      = 1'b0;
          sel_n     = SEL_NONE;
          state_nxt = GAP;
        end
      end else begin
        wcnt_n = wcnt + 1'b1;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latency counter, latched command and registered bus pins.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state    <= IDLE;
      wcnt     <= '0;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= SEL_NONE;
      dina_q   <= '0;
      cq_wr    <= 1'b0;
      cq_wdata <= '0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_n;
      en_q     <= en_n;
      wr_q     <= wr_n;
      addr_q   <= addr_n;
      sel_q    <= sel_n;
      dina_q   <= dina_n;
      cq_wr    <= cq_wr_n;
      cq_wdata <= cq_wdata_n;
    end
  end

  // Single-entry response slot; a fresh capture wins over consumption.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= bus.dout;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.enable    = en_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.sel       = sel_q;
  assign bus.dina      = dina_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state != IDLE) || !empty;
  assign bus.count     = fifo_cnt;
endmodule

// File: tb/tb_ahb_cmd_issuer.sv
// tb_ahb_cmd_issuer: cycle table for write and write-then-read, then
// directed sequences for FIFO fill under response back-pressure, reset
// during WAIT, and (with ISSUER_SELCHK_EN) dropped bad-sel commands.
module tb_ahb_cmd_issuer;
  import ahb_pkg::*;
  localparam int DEPTH = 4, AW = 32, DW = 32, RD_LAT = 2;

  logic hclk = 1'b0;
  logic hresetn = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ahb_cmd_issuer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bif ();
`ifdef ISSUER_SELCHK_EN
  logic err_drop;
`endif

  ahb_cmd_issuer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
`ifdef ISSUER_SELCHK_EN
    .err_drop(err_drop),
`endif
    .bus     (bif)
  );

  always #5 hclk = ~hclk;

  // dout: table-driven, or a simple slave returning D000_0000|addr.
  logic        use_tbl;
  logic [31:0] tbl_dout;
  always_comb bif.dout = use_tbl ? tbl_dout :
                         (bif.enable ? (32'hD000_0000 | bif.addr) : 32'h0);

  // Address-phase monitor: records addr/sel at each enable rise.
  logic [31:0] mon_addr[$];
  logic [2:0]  mon_sel[$];
  logic        en_prev = 1'b0;
  always @(negedge hclk) begin
    if (bif.enable && !en_prev) begin
      mon_addr.push_back(bif.addr);
      mon_sel.push_back(bif.sel);
    end
    en_prev <= bif.enable;
  end

  typedef struct {
    logic vld; logic wr; logic [2:0] sel; logic [31:0] wdata;
    logic [31:0] dout; logic rrdy;
    logic e_en; logic e_wr; logic [2:0] e_sel; logic [31:0] e_dina;
    logic e_rv; logic [31:0] e_rd; logic [2:0] e_cnt; logic e_busy;
  } vec_t;

  function automatic vec_t mk(logic vld, logic wr, logic [2:0] sel, logic [31:0] wdata,
                              logic [31:0] dout, logic rrdy, logic e_en, logic e_wr,
                              logic [2:0] e_sel, logic [31:0] e_dina, logic e_rv,
                              logic [31:0] e_rd, logic [2:0] e_cnt, logic e_busy);
    vec_t v;
    v.vld = vld; v.wr = wr; v.sel = sel; v.wdata = wdata; v.dout = dout; v.rrdy = rrdy;
    v.e_en = e_en; v.e_wr = e_wr; v.e_sel = e_sel; v.e_dina = e_dina;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    bif.cmd_valid = v;
    bif.cmd_wr    = w;
    bif.cmd_sel   = s;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
  endtask

  // Offer a command and wait (bounded) for it to be accepted.
  task automatic push_cmd(input string nm, input logic w, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    int n;
    drive(1'b1, w, s, a, d);
    n = 0;
    while (!bif.cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk(nm, 32'(bif.cmd_ready), 32'h1);
    step();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // Reset-state check shared by the start-up and mid-WAIT reset cases.
  task automatic chk_reset(input string p);
    chk({p, ".en"},   32'(bif.enable),    32'h0);
    chk({p, ".wr"},   32'(bif.wr),        32'h0);
    chk({p, ".sel"},  32'(bif.sel),       32'h4);
    chk({p, ".addr"}, bif.addr,           32'h0);
    chk({p, ".dina"}, bif.dina,           32'h0);
    chk({p, ".rv"},   32'(bif.rsp_valid), 32'h0);
    chk({p, ".rd"},   bif.rsp_rdata,      32'h0);
    chk({p, ".cnt"},  32'(bif.count),     32'h0);
    chk({p, ".busy"}, 32'(bif.busy),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[$];
    logic [31:0] exp_addr[7];
    logic [2:0]  exp_sel[7];
    int          n, rv_cnt, en_cnt;
    localparam logic [31:0] B = 32'hDEADBEEF, C = 32'hDEADC0DE, D = 32'h11111111;

    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bif.rsp_ready = 1'b1;
    use_tbl  = 1'b1;
    tbl_dout = 32'h0;

    //           vld   wr    sel   wdata dout  rrdy | en   wr    sel   dina rv    rd    cnt   busy
    // write {sel0, addr0, DEADBEEF}
    tv.push_back(mk(1'b1, 1'b1, 3'd0, B,    32'h0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0, 1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,32'h0, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,32'h0, 1'b1, 1'b1, 1'b1, 3'd0, B,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,32'h0, 1'b1, 1'b0, 1'b0, 3'd4, B,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,32'h0, 1'b1, 1'b0, 1'b0, 3'd4, B,     1'b0, 32'h0, 3'd0, 1'b0));
    // write {sel1, addr0, DEADC0DE} then read {sel1, addr0}
    tv.push_back(mk(1'b1, 1'b1, 3'd1, C,    D,     1'b1, 1'b0, 1'b0, 3'd4, B,     1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0,D,     1'b1, 1'b1, 1'b1, 3'd1, B,     1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b1, 1'b1, 3'd1, C,     1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b0, 1'b0, 3'd4, C,     1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b0, 1'b0, 3'd4, C,     1'b0, 32'h0, 3'd1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b1, 1'b0, 3'd1, C,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b1, 1'b0, 3'd1, C,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b1, 1'b0, 3'd1, C,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b1, 1'b0, 3'd1, C,     1'b0, 32'h0, 3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,C,     1'b1, 1'b0, 1'b0, 3'd4, C,     1'b1, C,     3'd0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,D,     1'b1, 1'b0, 1'b0, 3'd4, C,     1'b0, C,     3'd0, 1'b0));

    // Reset state
    repeat (3) step();
    chk_reset("rst");
    chk("rst.rdy", 32'(bif.cmd_ready), 32'h1);
`ifdef ISSUER_SELCHK_EN
    chk("rst.err_drop", 32'(err_drop), 32'h0);
`endif
    hresetn = 1'b0;

    // Cycle table
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].vld, tv[i].wr, tv[i].sel, 32'h0, tv[i].wdata);
      tbl_dout      = tv[i].dout;
      bif.rsp_ready = tv[i].rrdy;
      step();
      chk($sformatf("r%0d.en", i),   32'(bif.enable),    32'(tv[i].e_en));
      chk($sformatf("r%0d.wr", i),   32'(bif.wr),        32'(tv[i].e_wr));
      chk($sformatf("r%0d.sel", i),  32'(bif.sel),       32'(tv[i].e_sel));
      chk($sformatf("r%0d.addr", i), bif.addr,           32'h0);
      chk($sformatf("r%0d.dina", i), bif.dina,           tv[i].e_dina);
      chk($sformatf("r%0d.rv", i),   32'(bif.rsp_valid), 32'(tv[i].e_rv));
      chk($sformatf("r%0d.rd", i),   bif.rsp_rdata,      tv[i].e_rd);
      chk($sformatf("r%0d.cnt", i),  32'(bif.count),     32'(tv[i].e_cnt));
      chk($sformatf("r%0d.busy", i), 32'(bif.busy),      32'(tv[i].e_busy));
    end
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    use_tbl = 1'b0;

    // Two reads under back-pressure, then fill the FIFO behind them
    mon_addr.delete();
    mon_sel.delete();
    bif.rsp_ready = 1'b0;
    push_cmd("pushA", 1'b0, 3'd2, 32'h10, 32'h0);
    push_cmd("pushB", 1'b0, 3'd3, 32'h20, 32'h0);
    n = 0;
    while (!bif.rsp_valid && n < 30) begin
      step();
      n++;
    end
    chk("rspA.valid", 32'(bif.rsp_valid), 32'h1);
    chk("rspA.data",  bif.rsp_rdata,      32'hD000_0010);
    repeat (8) step();
    chk("waitB.en",   32'(bif.enable),    32'h1);
    chk("waitB.sel",  32'(bif.sel),       32'h3);
    chk("waitB.addr", bif.addr,           32'h20);
    chk("waitB.wr",   32'(bif.wr),        32'h0);
    chk("waitB.rv",   32'(bif.rsp_valid), 32'h1);
    chk("waitB.rd",   bif.rsp_rdata,      32'hD000_0010);
    for (int i = 0; i < 4; i++)
      push_cmd($sformatf("pushW%0d", i + 1), 1'b1, 3'(i % 4), 32'h100 + 32'(i), 32'(i + 1));
    chk("full.cnt", 32'(bif.count),     32'h4);
    chk("full.rdy", 32'(bif.cmd_ready), 32'h0);
    drive(1'b1, 1'b1, 3'd0, 32'h104, 32'h5);
    repeat (3) step();
    chk("hold5.cnt", 32'(bif.count),     32'h4);
    chk("hold5.rdy", 32'(bif.cmd_ready), 32'h0);
    bif.rsp_ready = 1'b1;
    step();
    bif.rsp_ready = 1'b0;
    chk("rspB.valid", 32'(bif.rsp_valid), 32'h1);
    chk("rspB.data",  bif.rsp_rdata,      32'hD000_0020);
    chk("rspB.gap",   32'(bif.sel),       32'h4);
    push_cmd("pushW5", 1'b1, 3'd0, 32'h104, 32'h5);
    chk("W5.cnt", 32'(bif.count), 32'h4);
    bif.rsp_ready = 1'b1;
    step();
    chk("rspB.drain", 32'(bif.rsp_valid), 32'h0);
    n = 0;
    while (bif.busy && n < 200) begin
      step();
      n++;
    end
    chk("drain.busy", 32'(bif.busy), 32'h0);
    exp_addr = '{32'h10, 32'h20, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
    exp_sel  = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    chk("order.n", 32'(mon_addr.size()), 32'd7);
    for (int i = 0; i < 7 && i < mon_addr.size(); i++) begin
      chk($sformatf("order%0d.addr", i), mon_addr[i],      exp_addr[i]);
      chk($sformatf("order%0d.sel", i),  32'(mon_sel[i]),  32'(exp_sel[i]));
    end

    // Reset during WAIT abandons the read
    push_cmd("pushR5", 1'b0, 3'd2, 32'h5, 32'h0);
    repeat (3) step();
    chk("midw.en",   32'(bif.enable), 32'h1);
    chk("midw.sel",  32'(bif.sel),    32'h2);
    chk("midw.addr", bif.addr,        32'h5);
    hresetn = 1'b1;
    step();
    chk_reset("midrst");
    hresetn = 1'b0;
    rv_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bif.rsp_valid) rv_cnt++;
      if (bif.enable) en_cnt++;
    end
    chk("midrst.no_rsp", 32'(rv_cnt), 32'h0);
    chk("midrst.no_en",  32'(en_cnt), 32'h0);

`ifdef ISSUER_SELCHK_EN
    // Out-of-range sel is accepted but dropped
    push_cmd("pushBad", 1'b1, 3'd4, 32'h5, 32'hDEADFACE);
    chk("bad.err", 32'(err_drop),  32'h1);
    chk("bad.cnt", 32'(bif.count), 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bif.enable) en_cnt++;
    end
    chk("bad.no_en", 32'(en_cnt),   32'h0);
    chk("bad.sticky", 32'(err_drop), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
